// File: rtl/bp_be_regfile_mp.sv
// Multi-port register file with synchronous reads, held read addresses that
// re-read every cycle, same-cycle write bypass and a config-bus debug channel.
module bp_be_regfile_mp #(
  parameter int data_width_p  = 64,
  parameter int els_p         = 32,
  parameter int read_ports_p  = 2,
  parameter int write_ports_p = 1,
  parameter int zero_x0_p     = 1,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    cfg_w_v_i,
  input  logic                                    cfg_r_v_i,
  input  logic [addr_width_lp-1:0]                cfg_addr_i,
  input  logic [data_width_p-1:0]                 cfg_data_i,
  output logic [data_width_p-1:0]                 cfg_data_o,
  input  logic [write_ports_p-1:0]                w_v_i,
  input  logic [write_ports_p*addr_width_lp-1:0]  w_addr_i,
  input  logic [write_ports_p*data_width_p-1:0]   w_data_i,
  input  logic [read_ports_p-1:0]                 r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0]   r_addr_i,
  output logic [read_ports_p*data_width_p-1:0]    r_data_o
);

  logic [data_width_p-1:0]  mem [els_p];

  logic [write_ports_p-1:0] wv;
  logic [addr_width_lp-1:0] waddr [write_ports_p];
  logic [data_width_p-1:0]  wdata [write_ports_p];

  logic [addr_width_lp-1:0] haddr [read_ports_p];
  logic [addr_width_lp-1:0] raddr [read_ports_p];
  logic [data_width_p-1:0]  rdata_n [read_ports_p];

  // Effective write set: config write takes over port 0, x0 writes and
  // writes during reset are dropped.
  always_comb begin
    for (int p = 0; p < write_ports_p; p++) begin
      wv[p]    = w_v_i[p] & ~reset_i;
      waddr[p] = w_addr_i[p*addr_width_lp +: addr_width_lp];
      wdata[p] = w_data_i[p*data_width_p +: data_width_p];
      if (p == 0 && cfg_w_v_i) begin
        wv[p]    = ~reset_i;
        waddr[p] = cfg_addr_i;
        wdata[p] = cfg_data_i;
      end
      if (zero_x0_p != 0 && waddr[p] == '0) begin
        wv[p] = 1'b0;
      end
    end
  end

  // Read address selection and bypass; later write ports override earlier ones.
  always_comb begin
    for (int r = 0; r < read_ports_p; r++) begin
      raddr[r] = r_v_i[r] ? r_addr_i[r*addr_width_lp +: addr_width_lp] : haddr[r];
      if (r == 0 && cfg_r_v_i) begin
        raddr[r] = cfg_addr_i;
      end
      rdata_n[r] = mem[raddr[r]];
      for (int p = 0; p < write_ports_p; p++) begin
        if (wv[p] && waddr[p] == raddr[r]) begin
          rdata_n[r] = wdata[p];
        end
      end
      if (zero_x0_p != 0 && raddr[r] == '0) begin
        rdata_n[r] = '0;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < write_ports_p; p++) begin
      if (wv[p]) begin
        mem[waddr[p]] <= wdata[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < read_ports_p; r++) begin
        haddr[r] <= '0;
      end
      r_data_o <= '0;
    end else begin
      for (int r = 0; r < read_ports_p; r++) begin
        // A config read borrows port 0 without disturbing its held operand.
        if (r_v_i[r] && !(r == 0 && cfg_r_v_i)) begin
          haddr[r] <= r_addr_i[r*addr_width_lp +: addr_width_lp];
        end
        r_data_o[r*data_width_p +: data_width_p] <= rdata_n[r];
      end
    end
  end

  assign cfg_data_o = r_data_o[data_width_p-1:0];

endmodule

// File: doc/bp_be_regfile_mp.md
# bp_be_regfile_mp

Parametrised multi-port register file for the BlackParrot backend, used for both the integer file (2 read, 1 write, hardwired x0) and the floating-point file (3 read for FMA, 1–2 write, no hardwired zero). Reads are synchronous with one-cycle latency. Each read port re-reads its last issued address every cycle, so held operands track writebacks across pipeline stalls. Same-cycle writes are bypassed into the read outputs, and a config-bus side channel gives debug read/write access.

## Interface
- data_width_p, 64, register width in bits
- els_p, 32, number of registers; power of 2; addr_width_lp = log2(els_p)
- read_ports_p, 2, number of read ports (1..4)
- write_ports_p, 1, number of write ports (1..2)
- zero_x0_p, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary

- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cfg_w_v_i  in  1  config write strobe
- cfg_r_v_i  in  1  config read strobe
- cfg_addr_i  in  addr_width_lp  config register address
- cfg_data_i  in  data_width_p  config write data
- cfg_data_o  out  data_width_p  config read data; equals read port 0 output
- w_v_i  in  write_ports_p  per-port write valid
- w_addr_i  in  write_ports_p*addr_width_lp  write addresses; port p at bits [p*aw +: aw]
- w_data_i  in  write_ports_p*data_width_p  write data
- r_v_i  in  read_ports_p  per-port issue strobe: capture a new address
- r_addr_i  in  read_ports_p*addr_width_lp  read addresses
- r_data_o  out  read_ports_p*data_width_p  registered read data

## Operation
- Storage is a flop array of els_p x data_width_p. Contents are not cleared by reset.
- Effective write set per cycle:
  - cfg_w_v_i=1 replaces write port 0 with (cfg_addr_i, cfg_data_i); w_v_i[0] is dropped that cycle.
  - Ports with equal addresses in the same cycle: the highest port index wins.
  - zero_x0_p=1: writes to address 0 are discarded.
- Per read port r, the held address haddr_r updates to r_addr_i[r] when r_v_i[r]=1 and is otherwise unchanged.
- Per read port r, the read address this cycle is raddr_r = r_v_i[r] ? r_addr_i[r] : haddr_r.
  - Exception: port 0 uses cfg_addr_i when cfg_r_v_i=1, and haddr_0 does not change.
- Output register update each cycle:
  - r_data_o[r] <= the effective write data if an effective write targets raddr_r this cycle (highest index wins);
  - otherwise mem[raddr_r];
  - forced to 0 when zero_x0_p=1 and raddr_r=0.
- cfg_data_o = r_data_o[0], combinationally.
- Config accesses are legal only while the pipeline is quiescent. The block does not arbitrate beyond the rules above.
- cfg_r_v_i and cfg_w_v_i may be asserted together:
  - The read returns the data being written, through the bypass.

## Timing
- Reset, in the cycle reset_i=1:
  - all haddr_r <= 0;
  - all r_data_o <= 0;
  - cfg_data_o = 0 in the following cycle;
  - writes presented during reset are ignored.
- Read latency is 1 cycle. Address issued at cycle N produces data at cycle N+1 that reflects every write at cycles ≤ N.
- While held (r_v_i=0), r_data_o at cycle N+1 reflects the held register including any write at cycle N. No stale data appears during stalls.
- A write at cycle N is visible in storage from cycle N+1. The bypass makes it visible at outputs in N+1 as well.
- Reset asserted mid-stall discards held addresses: outputs go to 0 and ports read address 0 until reissued.

## Test plan
- Basic read/write:
  - Write 0xDEAD_BEEF to r5 at cycle 0, then issue r5 on port 1 at cycle 2 -> r_data_o[1]=0xDEAD_BEEF at cycle 3.
- Same-cycle bypass:
  - Issue r7 on port 0 and write r7=0x1234 in the same cycle N -> r_data_o[0]=0x1234 at N+1.
- Stall tracking:
  - Issue r3 (holding 0x11), then deassert r_v_i for 5 cycles.
  - Write r3=0x22 in stall cycle 2 -> output is 0x11 through stall cycle 2 and 0x22 from stall cycle 3 onward.
- x0 and port conflict:
  - zero_x0_p=1: write r0=0xFF, then read r0 -> 0.
  - write_ports_p=2: both ports write r9 (0xA, 0xB) in one cycle -> subsequent read of r9 = 0xB.
  - zero_x0_p=0: r0 write/read round-trips 0xFF.
- Config bus:
  - cfg_w_v_i to r12=0x55 together with w_v_i[0] to r12=0x66 -> r12=0x55.
  - cfg_r_v_i to r12 -> cfg_data_o=0x55 next cycle.
  - Port 0 held address is unchanged afterward.
- Reset mid-operation:
  - Ports hold r4 and r6 (nonzero), then assert reset_i for 1 cycle -> all r_data_o=0 next cycle.
  - Storage r4/r6 is retained: reissuing r4 returns the old value.
